// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and fetch alignment ahead of instruction memory (optional PC_ALIGN_CHECK_EN)
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] read_address,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        if_valid,
   output logic        fetch_fault,
   output logic [31:0] fetch_count,
   output logic        misalign_fault
);

   // Highest byte address at which a whole instruction word still fits in memory.
   localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic        redirect_misaligned;
   logic        pc_out_of_range;

   assign pc_plus4        = pc + 32'd4;
   assign pc_out_of_range = (pc > LAST_WORD_ADDR);
   assign read_address    = pc;

`ifdef PC_ALIGN_CHECK_EN
   assign redirect_pc         = {redirect_target[31:2], 2'b00};
   assign redirect_misaligned = (redirect_target[1:0] != 2'b00);

   // Sticky record of any misaligned redirect; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_fault <= 1'b0;
      end else if (redirect_valid && redirect_misaligned) begin
         misalign_fault <= 1'b1;
      end
   end
`else
   assign redirect_pc         = redirect_target;
   assign redirect_misaligned = 1'b0;
   assign misalign_fault      = redirect_misaligned;
`endif

   // PC update and fetch-side alignment: redirect beats stall beats sequential.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         if_pc       <= RESET_PC;
         if_pc_plus4 <= RESET_PC + 32'd4;
         if_valid    <= 1'b0;
         fetch_fault <= 1'b0;
         fetch_count <= 32'd0;
      end else if (redirect_valid) begin
         // The word read this cycle is wrong-path: latch it as a bubble.
         pc          <= redirect_pc;
         if_pc       <= pc;
         if_pc_plus4 <= pc_plus4;
         if_valid    <= 1'b0;
         fetch_fault <= pc_out_of_range;
      end else if (!stall) begin
         pc          <= pc_plus4;
         if_pc       <= pc;
         if_pc_plus4 <= pc_plus4;
         if_valid    <= 1'b1;
         fetch_fault <= pc_out_of_range;
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] read_address;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        fetch_fault;
   logic [31:0] fetch_count;
   logic        misalign_fault;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit #(.RESET_PC(32'd0), .MEM_BYTES(1024)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .read_address    (read_address),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .if_valid        (if_valid),
      .fetch_fault     (fetch_fault),
      .fetch_count     (fetch_count),
      .misalign_fault  (misalign_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rv;
      logic [31:0] tgt;
      logic [31:0] e_ra;
      logic [31:0] e_pc;
      logic [31:0] e_p4;
      logic        e_v;
      logic        e_ff;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] ra, input logic [31:0] pc,
                            input logic [31:0] p4, input logic v, input logic ff,
                            input logic [31:0] cnt, input logic mis);
      check({tag, ".read_address"}, read_address, ra);
      check({tag, ".if_pc"}, if_pc, pc);
      check({tag, ".if_pc_plus4"}, if_pc_plus4, p4);
      check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
      check({tag, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, ff});
      check({tag, ".fetch_count"}, fetch_count, cnt);
      check({tag, ".misalign_fault"}, {31'd0, misalign_fault}, {31'd0, mis});
   endtask

   task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] t);
      reset           = r;
      stall           = s;
      redirect_valid  = rv;
      redirect_target = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        mis_exp;
      logic [31:0] ra66_exp;

      //          rst  stl  rv   tgt            ra             if_pc          plus4          v    ff   cnt
      vecs[0]  = '{1'b1,1'b0,1'b0,32'd0,        32'd0,         32'd0,         32'd4,         1'b0,1'b0,32'd0};
      vecs[1]  = '{1'b1,1'b0,1'b1,32'd500,      32'd0,         32'd0,         32'd4,         1'b0,1'b0,32'd0};
      vecs[2]  = '{1'b0,1'b0,1'b0,32'd0,        32'd4,         32'd0,         32'd4,         1'b1,1'b0,32'd1};
      vecs[3]  = '{1'b0,1'b0,1'b0,32'd0,        32'd8,         32'd4,         32'd8,         1'b1,1'b0,32'd2};
      vecs[4]  = '{1'b0,1'b1,1'b0,32'd0,        32'd8,         32'd4,         32'd8,         1'b1,1'b0,32'd2};
      vecs[5]  = '{1'b0,1'b1,1'b0,32'd0,        32'd8,         32'd4,         32'd8,         1'b1,1'b0,32'd2};
      vecs[6]  = '{1'b0,1'b1,1'b0,32'd0,        32'd8,         32'd4,         32'd8,         1'b1,1'b0,32'd2};
      vecs[7]  = '{1'b0,1'b0,1'b0,32'd0,        32'd12,        32'd8,         32'd12,        1'b1,1'b0,32'd3};
      vecs[8]  = '{1'b0,1'b0,1'b0,32'd0,        32'd16,        32'd12,        32'd16,        1'b1,1'b0,32'd4};
      vecs[9]  = '{1'b0,1'b0,1'b1,32'd64,       32'd64,        32'd16,        32'd20,        1'b0,1'b0,32'd4};
      vecs[10] = '{1'b0,1'b0,1'b0,32'd0,        32'd68,        32'd64,        32'd68,        1'b1,1'b0,32'd5};
      vecs[11] = '{1'b0,1'b1,1'b1,32'd100,      32'd100,       32'd68,        32'd72,        1'b0,1'b0,32'd5};
      vecs[12] = '{1'b0,1'b0,1'b0,32'd0,        32'd104,       32'd100,       32'd104,       1'b1,1'b0,32'd6};
      vecs[13] = '{1'b0,1'b0,1'b1,32'd1020,     32'd1020,      32'd104,       32'd108,       1'b0,1'b0,32'd6};
      vecs[14] = '{1'b0,1'b0,1'b0,32'd0,        32'd1024,      32'd1020,      32'd1024,      1'b1,1'b0,32'd7};
      vecs[15] = '{1'b0,1'b0,1'b0,32'd0,        32'd1028,      32'd1024,      32'd1028,      1'b1,1'b1,32'd8};
      vecs[16] = '{1'b0,1'b1,1'b0,32'd0,        32'd1028,      32'd1024,      32'd1028,      1'b1,1'b1,32'd8};
      vecs[17] = '{1'b0,1'b0,1'b1,32'hFFFFFFFC, 32'hFFFFFFFC,  32'd1028,      32'd1032,      1'b0,1'b1,32'd8};
      vecs[18] = '{1'b0,1'b0,1'b0,32'd0,        32'd0,         32'hFFFFFFFC,  32'd0,         1'b1,1'b1,32'd9};
      vecs[19] = '{1'b0,1'b0,1'b0,32'd0,        32'd4,         32'd0,         32'd4,         1'b1,1'b0,32'd10};
      vecs[20] = '{1'b1,1'b0,1'b1,32'd200,      32'd0,         32'd0,         32'd4,         1'b0,1'b0,32'd0};
      vecs[21] = '{1'b0,1'b0,1'b0,32'd0,        32'd4,         32'd0,         32'd4,         1'b1,1'b0,32'd1};

      reset = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 32'd0;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt);
         check_all($sformatf("v%0d", i), vecs[i].e_ra, vecs[i].e_pc, vecs[i].e_p4,
                   vecs[i].e_v, vecs[i].e_ff, vecs[i].e_cnt, 1'b0);
      end

      // Misaligned redirect from pc=4: aligned and sticky only with the check enabled.
`ifdef PC_ALIGN_CHECK_EN
      mis_exp  = 1'b1;
      ra66_exp = 32'd64;
`else
      mis_exp  = 1'b0;
      ra66_exp = 32'd66;
`endif
      step(1'b0, 1'b0, 1'b1, 32'd66);
      check_all("mis_redirect", ra66_exp, 32'd4, 32'd8, 1'b0, 1'b0, 32'd1, mis_exp);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check_all("mis_step", ra66_exp + 32'd4, ra66_exp, ra66_exp + 32'd4, 1'b1, 1'b0, 32'd2, mis_exp);
      step(1'b0, 1'b0, 1'b1, 32'd128);
      check_all("mis_sticky", 32'd128, ra66_exp + 32'd4, ra66_exp + 32'd8, 1'b0, 1'b0, 32'd2, mis_exp);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check_all("mis_reset", 32'd0, 32'd0, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
